// File: rtl/mem_arbiter_if.sv
// Bundle between the IFU/LSU requesters, the arbiter
// and the memory-side adapter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_rsp_valid;
   logic [DATA_W-1:0] ifu_rdata;

   logic                 lsu_req_valid;
   logic                lsu_req_ready;
   logic [ADDR_W-1:0]   lsu_addr;
   logic                lsu_wen;
   logic [DATA_W-1:0]   lsu_wdata;
   logic [DATA_W/8-1:0] lsu_wmask;
   logic                lsu_rsp_valid;
   logic [DATA_W-1:0]   lsu_rdata;

   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_wen;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wmask;
   logic                mem_rsp_valid;
   logic [DATA_W-1:0]   mem_rdata;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      input  lsu_req_valid, lsu_addr,
      input  lsu_wen, lsu_wdata, lsu_wmask,
      input  mem_req_ready, mem_rsp_valid,
      input  mem_rdata,
      output ifu_req_ready, ifu_rsp_valid,
      output ifu_rdata,
      output lsu_req_ready, lsu_rsp_valid,
      output lsu_rdata,
      output mem_req_valid, mem_addr,
      output mem_wen, mem_wdata, mem_wmask
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      output lsu_req_valid, lsu_addr,
      output lsu_wen, lsu_wdata, lsu_wmask,
      output mem_req_ready, mem_rsp_valid,
      output mem_rdata,
      input  ifu_req_ready, ifu_rsp_valid,
      input  ifu_rdata,
      input  lsu_req_ready, lsu_rsp_valid,
      input  lsu_rdata,
      input  mem_req_valid, mem_addr,
      input  mem_wen, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between
// IFU and LSU; one outstanding transaction at a time.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_e;

   localparam logic IFU = 1'b0;
   localparam logic LSU = 1'b1;
   localparam int   MW  = DATA_W / 8;

   state_e state_q, state_d;
   logic   last_q, last_d;
   logic   owner_q, owner_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MW-1:0]     wmask_q, wmask_d;

   logic gnt_ifu, gnt_lsu, rsp_fire;

   // Ready is gated by reset so no output leaks
   // while the block is held in reset.
   always_comb begin
      gnt_ifu = 1'b0;
      gnt_lsu = 1'b0;
      if (state_q == S_IDLE && reset) begin
         gnt_ifu = bus.ifu_req_valid &
                   (~bus.lsu_req_valid |
                    (last_q == LSU));
         gnt_lsu = bus.lsu_req_valid & ~gnt_ifu;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      unique case (state_q)
         S_IDLE: begin
            unique case (1'b1)
               gnt_lsu: begin
                  state_d = S_REQ;
                  last_d  = LSU;
                  owner_d = LSU;
                  addr_d  = bus.lsu_addr;
                  wen_d   = bus.lsu_wen;
                  wdata_d = bus.lsu_wdata;
                  wmask_d = bus.lsu_wmask;
               end
               gnt_ifu: begin
                  state_d = S_REQ;
                  last_d  = IFU;
                  owner_d = IFU;
                  addr_d  = bus.ifu_addr;
                  wen_d   = 1'b0;
                  wdata_d = '0;
                  wmask_d = '0;
               end
               default: ;
            endcase
         end
         S_REQ: begin
            if (bus.mem_req_ready)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mem_rsp_valid)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         last_q  <= LSU;
         owner_q <= IFU;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   assign rsp_fire = (state_q == S_WAIT) &
                     bus.mem_rsp_valid;

   assign bus.ifu_req_ready = gnt_ifu;
   assign bus.lsu_req_ready = gnt_lsu;

   assign bus.ifu_rsp_valid =
      rsp_fire & (owner_q == IFU);
   assign bus.lsu_rsp_valid =
      rsp_fire & (owner_q == LSU);

   assign bus.ifu_rdata = bus.ifu_rsp_valid ?
      bus.mem_rdata : '0;
   assign bus.lsu_rdata = bus.lsu_rsp_valid ?
      bus.mem_rdata : '0;

   assign bus.mem_req_valid = (state_q == S_REQ);
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wen       = wen_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_wmask     = wmask_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against
// a transaction-level round-robin reference model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   vectors = 0;
   int   miscompares = 0;
   // model state: 1 = LSU was granted last
   logic last_m;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic no_rsp(input string tag);
      chk({tag, " ifu_rsp_valid"}, bus.ifu_rsp_valid, 0);
      chk({tag, " lsu_rsp_valid"}, bus.lsu_rsp_valid, 0);
      chk({tag, " ifu_rdata"}, bus.ifu_rdata, 0);
      chk({tag, " lsu_rdata"}, bus.lsu_rdata, 0);
   endtask

   task automatic no_ready(input string tag);
      chk({tag, " ifu_req_ready"}, bus.ifu_req_ready, 0);
      chk({tag, " lsu_req_ready"}, bus.lsu_req_ready, 0);
   endtask

   task automatic chk_fields(input string tag,
                             input logic [31:0] a,
                             input logic w,
                             input logic [31:0] d,
                             input logic [3:0] m);
      chk({tag, " mem_addr"}, bus.mem_addr, a);
      chk({tag, " mem_wen"}, bus.mem_wen, w);
      chk({tag, " mem_wdata"}, bus.mem_wdata, d);
      chk({tag, " mem_wmask"}, bus.mem_wmask, m);
   endtask

   task automatic quiet_inputs();
      bus.ifu_req_valid = 0;
      bus.ifu_addr      = 0;
      bus.lsu_req_valid = 0;
      bus.lsu_addr      = 0;
      bus.lsu_wen       = 0;
      bus.lsu_wdata     = 0;
      bus.lsu_wmask     = 0;
      bus.mem_req_ready = 0;
      bus.mem_rsp_valid = 0;
      bus.mem_rdata     = 0;
   endtask

   task automatic scramble(input logic hold);
      bus.ifu_addr  = $urandom;
      bus.lsu_addr  = $urandom;
      bus.lsu_wen   = 1'($urandom);
      bus.lsu_wdata = $urandom;
      bus.lsu_wmask = 4'($urandom);
      if (!hold) begin
         bus.ifu_req_valid = 1'($urandom);
         bus.lsu_req_valid = 1'($urandom);
      end
   endtask

   // One transaction from IDLE back to IDLE.
   task automatic txn(input logic iv, input logic lv,
                      input logic [31:0] ia,
                      input logic [31:0] la,
                      input logic w,
                      input logic [31:0] wd,
                      input logic [3:0] wm,
                      input int stall, input int delay,
                      input logic [31:0] rd,
                      input logic hold);
      logic g;
      logic [31:0] ea, ed;
      logic ew;
      logic [3:0] em;
      g = (iv && lv) ? ~last_m : lv;
      last_m = g;
      ea = g ? la : ia;
      ew = g ? w : 1'b0;
      ed = g ? wd : 32'h0;
      em = g ? wm : 4'h0;

      bus.ifu_req_valid = iv;
      bus.ifu_addr      = ia;
      bus.lsu_req_valid = lv;
      bus.lsu_addr      = la;
      bus.lsu_wen       = w;
      bus.lsu_wdata     = wd;
      bus.lsu_wmask     = wm;
      #4;
      chk("grant ifu_req_ready", bus.ifu_req_ready, !g);
      chk("grant lsu_req_ready", bus.lsu_req_ready, g);
      chk("grant mem_req_valid", bus.mem_req_valid, 0);
      no_rsp("grant");
      next_cyc();

      for (int k = 0; k <= stall; k++) begin
         scramble(hold);
         bus.mem_req_ready = (k == stall);
         bus.mem_rdata = $urandom;
         #4;
         chk("req mem_req_valid", bus.mem_req_valid, 1);
         chk_fields("req", ea, ew, ed, em);
         no_ready("req");
         no_rsp("req");
         next_cyc();
      end
      bus.mem_req_ready = 0;

      for (int k = 0; k <= delay; k++) begin
         scramble(hold);
         bus.mem_rsp_valid = (k == delay);
         bus.mem_rdata = (k == delay) ? rd : $urandom;
         #4;
         chk("wait mem_req_valid", bus.mem_req_valid, 0);
         no_ready("wait");
         if (k < delay) begin
            no_rsp("wait");
         end else begin
            chk("rsp ifu_rsp_valid",
                bus.ifu_rsp_valid, !g);
            chk("rsp lsu_rsp_valid",
                bus.lsu_rsp_valid, g);
            chk("rsp ifu_rdata",
                bus.ifu_rdata, g ? 32'h0 : rd);
            chk("rsp lsu_rdata",
                bus.lsu_rdata, g ? rd : 32'h0);
         end
         next_cyc();
      end
      bus.mem_rsp_valid = 0;
      if (!hold) begin
         bus.ifu_req_valid = 0;
         bus.lsu_req_valid = 0;
      end
   endtask

   // Memory response while nothing is outstanding.
   task automatic stray();
      bus.ifu_req_valid = 0;
      bus.lsu_req_valid = 0;
      bus.mem_rsp_valid = 1;
      bus.mem_rdata     = $urandom;
      #4;
      no_rsp("stray");
      no_ready("stray");
      chk("stray mem_req_valid", bus.mem_req_valid, 0);
      next_cyc();
      bus.mem_rsp_valid = 0;
   endtask

   initial begin
      logic iv, lv;
      quiet_inputs();
      reset  = 0;
      last_m = 1'b1;
      next_cyc();
      next_cyc();
      bus.ifu_req_valid = 1;
      bus.mem_rsp_valid = 1;
      bus.mem_rdata     = 32'hFFFF_FFFF;
      #4;
      no_ready("reset");
      no_rsp("reset");
      chk("reset mem_req_valid", bus.mem_req_valid, 0);
      chk_fields("reset", 0, 0, 0, 0);
      quiet_inputs();
      reset = 1;
      next_cyc();

      txn(1, 0, 32'h8000_0000, 0, 0, 0, 0,
          0, 0, 32'h0010_0073, 0);

      txn(0, 1, 0, 32'h8000_1000, 1,
          32'hDEAD_BEEF, 4'h1,
          3, 0, $urandom, 0);

      for (int i = 0; i < 4; i++)
         txn(1, 1, $urandom, $urandom, 1'($urandom),
             $urandom, 4'($urandom),
             0, 0, $urandom, 1);
      bus.ifu_req_valid = 0;
      bus.lsu_req_valid = 0;

      stray();
      txn(0, 1, 0, $urandom, 0, 0, 0,
          0, 5, $urandom, 0);
      stray();
      txn(1, 0, $urandom, 0, 0, 0, 0,
          0, 0, $urandom, 0);

      for (int i = 0; i < 60; i++) begin
         iv = 1'($urandom);
         lv = 1'($urandom);
         if (!iv && !lv) iv = 1;
         if ($urandom_range(0, 4) == 0) stray();
         txn(iv, lv, $urandom, $urandom,
             1'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 3),
             $urandom_range(0, 3),
             $urandom, 1'($urandom));
      end

      // Reset in the middle of an IFU request.
      bus.ifu_req_valid = 1;
      bus.ifu_addr      = $urandom;
      bus.lsu_req_valid = 0;
      #4;
      chk("mid grant ifu_req_ready",
          bus.ifu_req_ready, 1);
      next_cyc();
      bus.ifu_req_valid = 0;
      #4;
      chk("mid mem_req_valid", bus.mem_req_valid, 1);
      #1;
      reset = 0;
      #1;
      chk("mid reset mem_req_valid",
          bus.mem_req_valid, 0);
      chk_fields("mid reset", 0, 0, 0, 0);
      no_ready("mid reset");
      no_rsp("mid reset");
      next_cyc();
      #2;
      reset = 1;
      last_m = 1'b1;
      next_cyc();
      stray();
      txn(1, 1, $urandom, $urandom, 1, $urandom,
          4'($urandom), 0, 0, $urandom, 0);
      txn(1, 1, $urandom, $urandom, 1, $urandom,
          4'($urandom), 1, 1, $urandom, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the multi-cycle NPC. It accepts one request at a time, forwards it to memory with a valid/ready handshake, and routes the memory response back to the requester that owns the transaction. Grants are round-robin when both requesters contend. The block sits between the IFU/LSU stages and the memory-side adapter that wraps `v_pmem_read`/`v_pmem_write`.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width. The byte mask is `DATA_W/8` bits.

- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ifu_req_valid`  in  1  IFU request.
- `ifu_req_ready`  out  1  IFU request accepted this cycle.
- `ifu_addr`  in  ADDR_W  fetch address.
- `ifu_rsp_valid`  out  1  fetch data valid (single-cycle pulse).
- `ifu_rdata`  out  DATA_W  fetch data.
- `lsu_req_valid`  in  1  LSU request.
- `lsu_req_ready`  out  1  LSU request accepted this cycle.
- `lsu_addr`  in  ADDR_W  load/store address.
- `lsu_wen`  in  1  1 = store, 0 = load.
- `lsu_wdata`  in  DATA_W  store data.
- `lsu_wmask`  in  DATA_W/8  store byte mask.
- `lsu_rsp_valid`  out  1  load data or store acknowledge (single-cycle pulse).
- `lsu_rdata`  out  DATA_W  load data.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  ADDR_W/1/DATA_W/DATA_W/8  registered request fields.
- `mem_rsp_valid`  in  1  memory response (reads and writes).
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- **FSM states:** IDLE, REQ, WAIT.
- **IDLE:** if any `*_req_valid`, grant one requester.
  - The granted requester sees `*_req_ready`=1 for exactly this cycle.
  - Its address is latched into `mem_addr`. For the LSU, `wen`/`wdata`/`wmask` are latched too.
  - For the IFU, `mem_wen`, `mem_wdata` and `mem_wmask` are latched as 0.
  - `owner` is set to the granted requester. Next state is REQ.
- **REQ:** `mem_req_valid`=1 with stable registered fields. On `mem_req_ready`=1, go to WAIT; otherwise stay in REQ.
- **WAIT:** on `mem_rsp_valid`=1:
  - `owner_rsp_valid`=1 combinationally in the same cycle; the other requester's `rsp_valid` stays 0.
  - `owner_rdata` = `mem_rdata`.
  - Next state is IDLE.
- **Arbitration:** a `last` register records the last-granted requester and is updated on each grant.
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not `last`.
  - `last` resets to LSU, so the first contended grant goes to the IFU.
- **Stores:** the memory acknowledges stores with `mem_rsp_valid`. `lsu_rsp_valid` pulses for stores as well; `lsu_rdata` carries no meaning on a store acknowledge.
- **Requester fields:** sampled only in the accept cycle. Requesters need not hold them afterwards.
- **Stray responses:** `mem_rsp_valid` outside WAIT is ignored, with no state change and no `rsp_valid`.
- `*_req_ready` is 0 in REQ and WAIT. Only one transaction is outstanding at a time.

## Timing
- **Reset (asynchronous, while `reset`=0):**
  - State = IDLE, `last` = LSU.
  - All outputs are 0, including `mem_req_valid`, which drops immediately even in the middle of a handshake.
  - An in-flight transaction is discarded, and a late `mem_rsp_valid` after reset release is ignored.
- **Minimum latency (zero-wait memory)**, with T = accept cycle:
  - T: `req_ready`.
  - T+1: REQ with `mem_req_ready`=1.
  - T+2: WAIT with `mem_rsp_valid` → `rsp_valid`.
  - T+3: next accept is possible.
- **Throughput:** at most one transaction per 3 cycles.
- Each memory stall cycle in REQ or WAIT adds exactly one cycle.
- `ifu_rdata` and `lsu_rdata` are 0 whenever their `rsp_valid` is 0.
- A requester that deasserts `req_valid` before it is granted is never served. Request withdrawal is legal.

## Test plan
- **Single fetch:** reset, then `ifu_req_valid`=1 with addr 0x80000000; memory has zero wait and returns 0x00100073 → `ifu_req_ready` at T, `mem_addr`=0x80000000 with `mem_wen`=0 at T+1, `ifu_rsp_valid`=1 with `ifu_rdata`=0x00100073 at T+2, `lsu_rsp_valid`=0 throughout.
- **Store forwarding:** LSU store to addr 0x80001000 with wdata 0xDEADBEEF and wmask 0x1; `mem_req_ready` withheld for 3 cycles → `mem_req_valid` with unchanged fields held for 4 cycles, then `lsu_rsp_valid` pulses on the acknowledge.
- **Contention:** both requesters valid continuously for 4 transactions → grant order IFU, LSU, IFU, LSU; each response goes only to its owner.
- **Response delay:** `mem_rsp_valid` delayed 5 cycles in WAIT; a stray `mem_rsp_valid` is injected while in IDLE → `rsp_valid` pulses once, after the delay; the stray pulse produces no output and no state change.
- **Reset mid-operation:** assert `reset`=0 in REQ, asynchronously between clock edges → `mem_req_valid` falls before the next edge; after release, the first contended grant goes to the IFU, and a `mem_rsp_valid` from the dropped transaction is ignored.
